// File: rtl/mem_master.sv
// mem_master: single-outstanding load/store master for a word-wide
// Avalon-style bus. Handles byte/half/word accesses, lane steering,
// load extension and misalignment detection.
module mem_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Misalignment of the request presented on the input ports
    always_comb begin
        w_misalign = (size == 2'd3) ||
                     ((size == 2'd1) && addr[0]) ||
                     ((size == 2'd2) && (addr[1:0] != 2'b00));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and outputs decoded from registered state
    always_comb begin
        w_next     = r_state;
        busy       = (r_state != IDLE);
        read       = (r_state == REQ) && !r_we;
        write      = (r_state == REQ) && r_we;
        done       = (r_state == RESP);
        err        = (r_state == RESP) && r_err;
        address    = {r_addr[31:2], 2'b00};
        rdata      = r_rdata;
        byteenable = '0;
        case (r_size)
            2'd0:    writedata = {4{r_wdata[7:0]}};
            2'd1:    writedata = {2{r_wdata[15:0]}};
            default: writedata = r_wdata;
        endcase
        if (r_state == REQ) begin
            case (r_size)
                2'd0:    byteenable = 4'b0001 << r_addr[1:0];
                2'd1:    byteenable = r_addr[1] ? 4'b1100 : 4'b0011;
                2'd2:    byteenable = 4'b1111;
                default: byteenable = '0;
            endcase
        end
        case (r_state)
            IDLE:    if (start) w_next = w_misalign ? RESP : REQ;
            REQ:     if (!waitrequest) w_next = r_we ? RESP : DATA;
            DATA:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Lane selection and extension of the returning load data
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = readdata[7:0];
            2'd1:    w_byte = readdata[15:8];
            2'd2:    w_byte = readdata[23:16];
            default: w_byte = readdata[31:24];
        endcase
        w_half = r_addr[1] ? readdata[31:16] : readdata[15:0];
        case (r_size)
            2'd0:    w_load = {{24{r_sign & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load = readdata;
        endcase
    end

    // Request capture in IDLE and load-result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_we    <= we;
                r_size  <= size;
                r_sign  <= sign_ext;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_err   <= w_misalign;
            end
            if (r_state == DATA) r_rdata <= w_load;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed self-checking bench for mem_master.
module tb_mem_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the last transaction
    int          res_dcyc;
    int          res_dcnt;
    int          res_rdc;
    int          res_wrc;
    logic        res_both;
    logic        res_stable;
    logic [31:0] res_adr;
    logic [3:0]  res_be;
    logic [31:0] res_wd;
    logic        res_err;
    logic [31:0] res_rdata;
    int          rst_dcnt;

    mem_master dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .we          (we),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Issue one request and watch 12 cycles, acting as the bus slave.
    // A second start is pulsed while busy to show it is ignored.
    task automatic xfer(input logic t_we, input logic [1:0] t_size, input logic t_sx,
                        input logic [31:0] t_addr, input logic [31:0] t_wd,
                        input logic [31:0] t_rd, input int waits);
        logic seen;
        logic rd_ok;
        int   wcount;
        seen = 0; rd_ok = 0; wcount = 0;
        res_dcyc = 0; res_dcnt = 0; res_rdc = 0; res_wrc = 0;
        res_both = 0; res_stable = 1; res_adr = '0; res_be = '0; res_wd = '0;
        res_err = 0; res_rdata = '0;
        @(negedge clk);
        start = 1'b1; we = t_we; size = t_size; sign_ext = t_sx; addr = t_addr; wdata = t_wd;
        waitrequest = 1'b0; readdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (read && write) res_both = 1;
            if (read)  res_rdc++;
            if (write) res_wrc++;
            if (read || write) begin
                if (!seen) begin
                    seen = 1; res_adr = address; res_be = byteenable; res_wd = writedata;
                end else if (address !== res_adr || byteenable !== res_be || writedata !== res_wd) begin
                    res_stable = 0;
                end
            end
            if (done) begin
                res_dcnt++;
                if (res_dcyc == 0) begin
                    res_dcyc = c; res_err = err; res_rdata = rdata;
                end
            end
            readdata = rd_ok ? t_rd : 32'h5A5A5A5A;
            if ((read || write) && wcount < waits) begin
                waitrequest = 1'b1; wcount++;
            end else begin
                waitrequest = 1'b0;
            end
            rd_ok = read && !waitrequest;
            if (c == 1) begin
                start = 1'b1; we = ~t_we; size = 2'd2; addr = t_addr ^ 32'h40;
            end
            if (c == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        readdata = 32'h5A5A5A5A;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; we = 1'b0; size = '0; sign_ext = 1'b0;
        addr = '0; wdata = '0; readdata = 32'h5A5A5A5A; waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_address", address, 0);
        check("rst_be", byteenable, 0);
        check("rst_wd", writedata, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b1;

        // Aligned word store
        xfer(1'b1, 2'd2, 1'b0, 32'hBFC00010, 32'hDEADBEEF, 32'h0, 0);
        check("wst_done_cyc", res_dcyc, 2);
        check("wst_done_cnt", res_dcnt, 1);
        check("wst_wr_cyc", res_wrc, 1);
        check("wst_rd_cyc", res_rdc, 0);
        check("wst_addr", res_adr, 32'hBFC00010);
        check("wst_be", res_be, 4'b1111);
        check("wst_wd", res_wd, 32'hDEADBEEF);
        check("wst_err", res_err, 0);
        check("wst_rdata_hold", res_rdata, 0);

        // Signed byte load, top lane
        xfer(1'b0, 2'd0, 1'b1, 32'hBFC00003, 32'h0, 32'h80FF1234, 0);
        check("lbs_done_cyc", res_dcyc, 3);
        check("lbs_rd_cyc", res_rdc, 1);
        check("lbs_wr_cyc", res_wrc, 0);
        check("lbs_addr", res_adr, 32'hBFC00000);
        check("lbs_be", res_be, 4'b1000);
        check("lbs_rdata", res_rdata, 32'hFFFFFF80);
        check("lbs_err", res_err, 0);

        // Same load, zero-extended
        xfer(1'b0, 2'd0, 1'b0, 32'hBFC00003, 32'h0, 32'h80FF1234, 0);
        check("lbu_rdata", res_rdata, 32'h00000080);

        // Signed byte load, lane 1 with positive byte
        xfer(1'b0, 2'd0, 1'b1, 32'hBFC00001, 32'h0, 32'h80FF1234, 0);
        check("lb1_be", res_be, 4'b0010);
        check("lb1_rdata", res_rdata, 32'h00000012);

        // Half store, upper lane
        xfer(1'b1, 2'd1, 1'b0, 32'hBFC00006, 32'h0000ABCD, 32'h0, 0);
        check("hst_done_cyc", res_dcyc, 2);
        check("hst_be", res_be, 4'b1100);
        check("hst_wd", res_wd, 32'hABCDABCD);
        check("hst_addr", res_adr, 32'hBFC00004);
        check("hst_rdata_hold", res_rdata, 32'h00000012);

        // Byte store, lane 2
        xfer(1'b1, 2'd0, 1'b0, 32'hBFC0000A, 32'h123456A5, 32'h0, 0);
        check("bst_be", res_be, 4'b0100);
        check("bst_wd", res_wd, 32'hA5A5A5A5);

        // Signed half load, lower lane
        xfer(1'b0, 2'd1, 1'b1, 32'hBFC00004, 32'h0, 32'h1234F00D, 0);
        check("lhl_be", res_be, 4'b0011);
        check("lhl_rdata", res_rdata, 32'hFFFFF00D);

        // Word load with three stall cycles
        xfer(1'b0, 2'd2, 1'b0, 32'hBFC00008, 32'h0, 32'h12345678, 3);
        check("lws_rd_cyc", res_rdc, 4);
        check("lws_stable", res_stable, 1);
        check("lws_addr", res_adr, 32'hBFC00008);
        check("lws_done_cyc", res_dcyc, 6);
        check("lws_done_cnt", res_dcnt, 1);
        check("lws_rdata", res_rdata, 32'h12345678);
        check("lws_both", res_both, 0);

        // Signed half load, upper lane, stalled
        xfer(1'b0, 2'd1, 1'b1, 32'hBFC00002, 32'h0, 32'h80017FFF, 2);
        check("lhu_rd_cyc", res_rdc, 3);
        check("lhu_done_cyc", res_dcyc, 5);
        check("lhu_rdata", res_rdata, 32'hFFFF8001);

        // Misaligned word load
        xfer(1'b0, 2'd2, 1'b0, 32'hBFC00002, 32'h0, 32'h11111111, 0);
        check("mis_rd_cyc", res_rdc, 0);
        check("mis_wr_cyc", res_wrc, 0);
        check("mis_done_cyc", res_dcyc, 1);
        check("mis_done_cnt", res_dcnt, 1);
        check("mis_err", res_err, 1);
        check("mis_rdata_hold", res_rdata, 32'hFFFF8001);

        // Misaligned half store
        xfer(1'b1, 2'd1, 1'b0, 32'hBFC00001, 32'hFFFF, 32'h0, 0);
        check("mhs_wr_cyc", res_wrc, 0);
        check("mhs_err", res_err, 1);

        // Reserved size on an aligned address
        xfer(1'b0, 2'd3, 1'b0, 32'hBFC00000, 32'h0, 32'h0, 0);
        check("rsv_rd_cyc", res_rdc, 0);
        check("rsv_err", res_err, 1);
        check("rsv_done_cyc", res_dcyc, 1);

        // Reset while stalled in REQ
        @(negedge clk);
        start = 1'b1; we = 1'b0; size = 2'd2; addr = 32'hBFC00020; waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mrst_read_pre", read, 1);
        @(posedge clk); #1;
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("mrst_read", read, 0);
        check("mrst_busy", busy, 0);
        check("mrst_address", address, 0);
        check("mrst_rdata", rdata, 0);
        rst_dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) rst_dcnt++;
        end
        waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        if (done) rst_dcnt++;
        check("mrst_no_done", rst_dcnt, 0);

        xfer(1'b0, 2'd2, 1'b0, 32'hBFC00024, 32'h0, 32'hCAFEF00D, 0);
        check("post_done_cyc", res_dcyc, 3);
        check("post_done_cnt", res_dcnt, 1);
        check("post_rdata", res_rdata, 32'hCAFEF00D);
        check("post_addr", res_adr, 32'hBFC00024);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
